// File: rtl/pipe_hazard_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_hazard_ctrl_if
//  Description : Signal bundle between the 5-stage datapath and the pipeline
//                sequencing controller. The controller takes the slave
//                modport. The datapath, or a testbench, takes the master
//                modport.
//                Optional macro PIPE_CTRL_PERF_EN adds the performance
//                counter outputs.
//  Revision    : 1.0 - initial release
// ============================================================================
interface pipe_hazard_ctrl_if;
  // Hazard sources from the datapath
  logic [4:0]  id_rs_addr;
  logic [4:0]  id_rt_addr;
  logic        id_uses_rt;
  logic        ex_mem_read;
  logic [4:0]  ex_rt_addr;
  logic        mem_branch_taken;
  logic        mem_jump;
  logic        mem_access;
  logic        dmem_ready;
  logic        halt_req;
  logic        resume;
  // Pipeline register controls
  logic        pc_en;
  logic        if_id_en;
  logic        id_ex_en;
  logic        ex_mem_en;
  logic        mem_wb_en;
  logic        if_id_flush;
  logic        id_ex_flush;
  logic        ex_mem_flush;
  // Status
  logic        halted;
  logic        err_timeout;
  logic [1:0]  state;
`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] perf_stall;
  logic [31:0] perf_flush;
  logic [31:0] perf_wait;
`endif

  modport master (
    output id_rs_addr, id_rt_addr, id_uses_rt, ex_mem_read, ex_rt_addr,
           mem_branch_taken, mem_jump, mem_access, dmem_ready, halt_req, resume,
    input  pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
           if_id_flush, id_ex_flush, ex_mem_flush, halted, err_timeout, state
`ifdef PIPE_CTRL_PERF_EN
           , perf_stall, perf_flush, perf_wait
`endif
  );

  modport slave (
    input  id_rs_addr, id_rt_addr, id_uses_rt, ex_mem_read, ex_rt_addr,
           mem_branch_taken, mem_jump, mem_access, dmem_ready, halt_req, resume,
    output pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
           if_id_flush, id_ex_flush, ex_mem_flush, halted, err_timeout, state
`ifdef PIPE_CTRL_PERF_EN
           , perf_stall, perf_flush, perf_wait
`endif
  );
endinterface
`default_nettype wire

// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_hazard_ctrl
//  Description : Pipeline sequencing controller for the 5-stage MIPS core.
//                It owns every enable and flush line of the PC and the
//                pipeline registers. It handles memory-wait freeze, MEM-stage
//                redirect, load-use bubbles and the debug
//                halt/drain/resume sequence.
//                Optional macro PIPE_CTRL_PERF_EN adds the stall, flush and
//                wait event counters.
//  Revision    : 1.0 - initial release
// ============================================================================
module pipe_hazard_ctrl #(
  parameter int DRAIN_CYCLES = 4,
  parameter int WAIT_TIMEOUT = 255
) (
  input  wire               clk,
  input  wire               reset,
  pipe_hazard_ctrl_if.slave bus
);

  localparam int DRAIN_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam int WAIT_W  = (WAIT_TIMEOUT > 1) ? $clog2(WAIT_TIMEOUT + 1) : 1;
  localparam logic [DRAIN_W-1:0] C_DRAIN_LAST = DRAIN_W'(DRAIN_CYCLES - 1);
  localparam logic [WAIT_W-1:0]  C_WAIT_LAST  = WAIT_W'(WAIT_TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_HALTED = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [DRAIN_W-1:0]  drain_q, drain_d;
  logic [WAIT_W-1:0]   wait_q,  wait_d;
  logic                err_q,   err_d;

  logic w_freeze;
  logic w_redirect;
  logic w_load_use;
  logic w_pc_en, w_if_id_en, w_id_ex_en, w_ex_mem_en, w_mem_wb_en;
  logic w_if_id_flush, w_id_ex_flush, w_ex_mem_flush;

  assign w_freeze   = bus.mem_access & ~bus.dmem_ready;
  assign w_redirect = bus.mem_branch_taken | bus.mem_jump;
  assign w_load_use = bus.ex_mem_read && (bus.ex_rt_addr != 5'd0) &&
                      ((bus.ex_rt_addr == bus.id_rs_addr) ||
                       (bus.id_uses_rt && (bus.ex_rt_addr == bus.id_rt_addr)));

  // State, counter and sticky error registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_RUN;
      drain_q <= '0;
      wait_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      drain_q <= drain_d;
      wait_q  <= wait_d;
      err_q   <= err_d;
    end
  end

  // Next state: freeze holds the sequence and runs the wait timer. Otherwise
  // the halt/drain/resume sequence advances.
  always_comb begin
    state_d = state_q;
    drain_d = drain_q;
    wait_d  = '0;
    err_d   = err_q;
    if ((state_q != ST_HALTED) && w_freeze) begin
      if (wait_q == C_WAIT_LAST) begin
        err_d   = 1'b1;
        state_d = ST_HALTED;
      end else begin
        wait_d = wait_q + 1'b1;
      end
    end else begin
      case (state_q)
        ST_RUN: begin
          // A halt request that meets any hazard is dropped, not queued.
          if (bus.halt_req && !w_redirect && !w_load_use) begin
            state_d = ST_DRAIN;
            drain_d = '0;
          end
        end
        ST_DRAIN: begin
          if (drain_q == C_DRAIN_LAST) begin
            state_d = ST_HALTED;
          end else begin
            drain_d = drain_q + 1'b1;
          end
        end
        ST_HALTED: begin
          if (bus.resume && !err_q) begin
            state_d = ST_RUN;
          end
        end
        default: state_d = ST_RUN;
      endcase
    end
  end

  // Enable and flush decode in priority order. The result is valid in the
  // same cycle as the hazard.
  // A load-use hazard inside DRAIN still stalls. The stalled ID instruction
  // is kept and not flushed, so the PC held for resume stays consistent.
  always_comb begin
    w_pc_en        = 1'b1;
    w_if_id_en     = 1'b1;
    w_id_ex_en     = 1'b1;
    w_ex_mem_en    = 1'b1;
    w_mem_wb_en    = 1'b1;
    w_if_id_flush  = 1'b0;
    w_id_ex_flush  = 1'b0;
    w_ex_mem_flush = 1'b0;
    if (reset || (state_q == ST_HALTED) || w_freeze) begin
      w_pc_en     = 1'b0;
      w_if_id_en  = 1'b0;
      w_id_ex_en  = 1'b0;
      w_ex_mem_en = 1'b0;
      w_mem_wb_en = 1'b0;
    end else if (w_redirect) begin
      w_if_id_flush  = 1'b1;
      w_id_ex_flush  = 1'b1;
      w_ex_mem_flush = 1'b1;
    end else if (w_load_use) begin
      w_pc_en       = 1'b0;
      w_if_id_en    = 1'b0;
      w_id_ex_flush = 1'b1;
    end else if (state_q == ST_DRAIN) begin
      w_pc_en       = 1'b0;
      w_if_id_flush = 1'b1;
    end
  end

  assign bus.pc_en        = w_pc_en;
  assign bus.if_id_en     = w_if_id_en;
  assign bus.id_ex_en     = w_id_ex_en;
  assign bus.ex_mem_en    = w_ex_mem_en;
  assign bus.mem_wb_en    = w_mem_wb_en;
  assign bus.if_id_flush  = w_if_id_flush;
  assign bus.id_ex_flush  = w_id_ex_flush;
  assign bus.ex_mem_flush = w_ex_mem_flush;
  assign bus.halted       = ~reset & (state_q == ST_HALTED);
  assign bus.err_timeout  = err_q;
  assign bus.state        = state_q;

`ifdef PIPE_CTRL_PERF_EN
  logic        w_active;
  logic [31:0] perf_stall_q, perf_flush_q, perf_wait_q;

  assign w_active = (state_q != ST_HALTED);

  // Event counters follow the same qualified decode that drives the enables.
  // They wrap naturally at 2^32.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_stall_q <= 32'd0;
      perf_flush_q <= 32'd0;
      perf_wait_q  <= 32'd0;
    end else if (w_active) begin
      if (w_freeze) begin
        perf_wait_q <= perf_wait_q + 32'd1;
      end else if (w_redirect) begin
        perf_flush_q <= perf_flush_q + 32'd1;
      end else if (w_load_use) begin
        perf_stall_q <= perf_stall_q + 32'd1;
      end
    end
  end

  assign bus.perf_stall = perf_stall_q;
  assign bus.perf_flush = perf_flush_q;
  assign bus.perf_wait  = perf_wait_q;
`else
  // Performance counters are not built in this configuration.
`endif

endmodule
`default_nettype wire

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Pipeline sequencing controller for the 5-stage MIPS core. It drives the enable and flush inputs of the PC register and the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers. It inserts load-use bubbles, squashes wrong-path instructions when a branch or jump resolves in MEM, freezes the whole pipeline while data memory is not ready, and runs a halt/drain/resume sequence for debug. It sits beside the datapath and owns every `en`/flush line.

## Interface
- `DRAIN_CYCLES`, default 4: bubble cycles needed to empty IF/ID through MEM/WB on halt.
- `WAIT_TIMEOUT`, default 255: maximum consecutive memory-wait cycles before the timeout error.
- `clk` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: asynchronous, active-high.
- `id_rs_addr`, `id_rt_addr` in 5: source registers of the instruction in ID.
- `id_uses_rt` in 1: the ID instruction reads rt as a source.
- `ex_mem_read` in 1, `ex_rt_addr` in 5: the ID/EX load flag and its destination register.
- `mem_branch_taken`, `mem_jump` in 1: redirect resolved in the MEM stage.
- `mem_access` in 1: EX/MEM MemRead or MemWrite is asserted.
- `dmem_ready` in 1: data memory has completed the access.
- `halt_req`, `resume` in 1: single-cycle debug pulses.
- `pc_en`, `if_id_en`, `id_ex_en`, `ex_mem_en`, `mem_wb_en` out 1: register enables.
- `if_id_flush`, `id_ex_flush`, `ex_mem_flush` out 1: synchronous clear of the named register on this edge.
- `halted` out 1: pipeline is stopped and empty.
- `err_timeout` out 1: sticky memory-wait timeout.
- `state` out 2: current FSM state, encoded RUN=0, DRAIN=1, HALTED=2.

## Operation
- Internal hazard signals, evaluated each cycle:
  - freeze = `mem_access` & !`dmem_ready`.
  - redirect = `mem_branch_taken` | `mem_jump`.
  - load_use = `ex_mem_read` & (`ex_rt_addr` != 0) & ((`ex_rt_addr` == `id_rs_addr`) | (`id_uses_rt` & (`ex_rt_addr` == `id_rt_addr`))).
- Priority (highest first): freeze > redirect > load_use > `halt_req`.
- freeze, in any state other than HALTED:
  - All five enables are 0 and all flushes are 0.
  - The wait counter increments.
  - The FSM state and the drain counter hold.
- Wait counter:
  - Clears on any cycle without freeze.
  - When it reaches `WAIT_TIMEOUT` with freeze still high, `err_timeout` sets and the FSM goes to HALTED.
  - `err_timeout` clears only on `reset`.
- redirect (no freeze): all enables are 1 and `if_id_flush`, `id_ex_flush`, `ex_mem_flush` are all 1, so the PC loads the target.
- load_use (no freeze, no redirect): `pc_en`=0, `if_id_en`=0, `id_ex_flush`=1, remaining enables 1. This is exactly one bubble per hazard.
- Otherwise: all enables are 1 and all flushes are 0.
- RUN:
  - `halt_req` with no freeze, redirect or load_use: go to DRAIN and set the drain counter to 0.
  - `halt_req` in any other cycle is dropped, not queued.
- DRAIN:
  - `pc_en`=0 and `if_id_flush`=1 on every non-frozen cycle; the other stages advance.
  - redirect during DRAIN behaves as above, so the correct PC is kept for resume.
  - The drain counter increments on non-frozen cycles.
  - When the counter reaches `DRAIN_CYCLES`-1, go to HALTED.
- HALTED:
  - All enables are 0, all flushes are 0 and `halted`=1. Inputs other than `resume` are ignored.
  - `resume` moves the FSM to RUN.
  - `resume` is ignored while `err_timeout`=1.

## Timing
- Reset values: `state`=RUN, both counters 0, `err_timeout`=0, `halted`=0.
- While `reset` is high, all enables and flushes are forced to 0. The first edge after deassertion runs normally.
- Enables and flushes are combinational from the inputs and the registered state, valid in the same cycle. No added latency.
- Entering DRAIN takes effect on the cycle after `halt_req`.
- `halted` rises exactly `DRAIN_CYCLES` non-frozen cycles after DRAIN entry.
- RUN enables are active in the cycle after `resume`.
- A `reset` pulse mid-DRAIN or mid-wait aborts the sequence and returns the block to RUN.

## Configuration
- `PIPE_CTRL_PERF_EN` defined: adds outputs `perf_stall` [31:0], `perf_flush` [31:0] and `perf_wait` [31:0].
  - `perf_stall` counts load_use bubbles.
  - `perf_flush` counts redirect cycles.
  - `perf_wait` counts freeze cycles.
  - All three reset to 0 and wrap at 2^32.
- `PIPE_CTRL_PERF_EN` undefined: these ports and counters do not exist. All other behaviour is identical.

## Test plan
- Load-use: `ex_mem_read`=1, `ex_rt_addr`=5, `id_rs_addr`=5 for one cycle -> `pc_en`=0, `if_id_en`=0, `id_ex_flush`=1 for exactly one cycle. The same stimulus with `ex_rt_addr`=0 -> no stall.
- Redirect over load-use: `mem_branch_taken`=1 together with a load_use match -> all three flushes 1 and `pc_en`=1.
- Memory wait: `mem_access`=1, `dmem_ready`=0 for 3 cycles -> all enables 0 for those 3 cycles, then normal once `dmem_ready`=1. Holding wait for 255 cycles -> `err_timeout`=1 and `state`=HALTED.
- Halt/resume: pulse `halt_req` in a clean cycle -> `state`=DRAIN for 4 cycles with `if_id_flush`=1, then `halted`=1. Pulse `resume` -> `state`=RUN with all enables 1 on the next cycle.
- Drain with freeze: freeze for 2 cycles during DRAIN -> `halted` is delayed by exactly 2 cycles.
- Reset mid-drain: assert `reset` in DRAIN cycle 2 -> outputs go to 0 immediately; after release, `state`=RUN and `halted`=0.
